// File: rtl/dm_dma_master.sv
// Word-copy DMA initiator on the data-memory bus: RD -> WT -> WR per word, 3 cycles each.
// Optional build macro DMA_FILL_EN adds a write-only fill mode (fill_mode/fill_value ports).

`ifndef DM_OP_WD
`define DM_OP_WD 3'b010
`endif

module dm_dma_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             dm_w,
    output logic             dm_r,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    output logic [2:0]       dm_op,
    input  logic [31:0]      rdata
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StWt   = 3'd2;
    localparam logic [2:0] StWr   = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;
    logic             accept;
    logic             misaligned;
    logic             fill_q;
    logic [31:0]      fval_q;

    // Abort has priority over start in IDLE.
    assign accept = (state_q == StIdle) && start && !abort;

`ifdef DMA_FILL_EN
    assign misaligned = (dst_addr[1:0] != 2'b00) ||
                        (!fill_mode && (src_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
            fval_q <= 32'h0;
        end else if (accept) begin
            fill_q <= fill_mode;
            fval_q <= fill_value;
        end
    end
`else
    assign misaligned = (dst_addr[1:0] != 2'b00) || (src_addr[1:0] != 2'b00);
    assign fill_q     = 1'b0;
    assign fval_q     = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = len_words;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (len_words == '0) begin
                        state_d = StDone;
                    end else if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = fill_q_next() ? StWr : StRd;
                    end
                end
            end
            StRd: begin
                state_d = abort ? StDone : StWt;
            end
            StWt: begin
                if (abort) begin
                    state_d = StDone;
                end else begin
                    buf_d   = rdata;
                    state_d = StWr;
                end
            end
            StWr: begin
                // The write already committed at the negedge inside WR, so it counts even on abort.
                cnt_d = cnt_q + LEN_W'(1);
                rem_d = rem_q - LEN_W'(1);
                src_d = src_q + 32'd4;
                dst_d = dst_q + 32'd4;
                if (abort || (rem_q == LEN_W'(1))) begin
                    state_d = StDone;
                end else begin
                    state_d = fill_q ? StWr : StRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Fill mode is chosen by the value being latched this cycle, not the stale register.
    function automatic logic fill_q_next();
`ifdef DMA_FILL_EN
        return fill_mode;
`else
        return 1'b0;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            rem_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        dm_r  = 1'b0;
        dm_w  = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        unique case (state_q)
            StRd, StWt: begin
                busy = 1'b1;
                dm_r = 1'b1;
                addr = src_q;
            end
            StWr: begin
                busy  = 1'b1;
                dm_w  = 1'b1;
                addr  = dst_q;
                wdata = fill_q ? fval_q : buf_q;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err        = err_q;
    assign words_done = cnt_q;
    assign dm_op      = `DM_OP_WD;

endmodule

// File: tb/tb_dm_dma_master.sv
// Randomized bench for dm_dma_master against a word-level copy model and a bus responder.
// Cycle 0 is the cycle in which start is driven; a copy of N words finishes with done in cycle 3N+1.

`ifndef DM_OP_WD
`define DM_OP_WD 3'b010
`endif

module tb_dm_dma_master;

    localparam logic [31:0] LedAddr = 32'hbf80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] len_words = 16'h0;
`ifdef DMA_FILL_EN
    logic        fill_mode = 1'b0;
    logic [31:0] fill_value = 32'h0;
`endif
    logic        busy, done, err, dm_w, dm_r;
    logic [15:0] words_done;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  dm_op;

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] io_led = 32'h0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap = 0;
    int          n_vec = 0;
    int          n_err = 0;

    dm_dma_master #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
`ifdef DMA_FILL_EN
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .dm_w       (dm_w),
        .dm_r       (dm_r),
        .addr       (addr),
        .wdata      (wdata),
        .dm_op      (dm_op),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    // Bus responder: registered read data, writes committed at the negedge.
    initial rdata = 32'h0;
    always @(posedge clk) begin
        if (dm_r) rdata <= mem.exists(addr) ? mem[addr] : 32'h0;
        if (!rst) begin
            rd_cnt <= rd_cnt + (dm_r ? 1 : 0);
            wr_cnt <= wr_cnt + (dm_w ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (dm_w) begin
            mem[addr] = wdata;
            if (addr == LedAddr) io_led = wdata;
        end
        if (dm_r && dm_w) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // One copy transfer. ab: cycle from which abort is held (0 = none).
    // ign: cycle carrying a stray start with garbage operands (0 = none).
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                            input int ab, input int ign, input bit preload);
        int          cyc;
        int          done_cyc;
        int          ndone;
        int          exp_w;
        int          exp_cyc;
        logic [31:0] w;
        if (preload) begin
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                mem[s + 32'(4 * i)]     = w;
                ref_mem[s + 32'(4 * i)] = w;
            end
        end
        exp_w   = len;
        exp_cyc = 3 * len + 1;
        if (ab >= 1 && ab <= 3 * len) begin
            // Word k occupies cycles RD=1+3k, WT=2+3k, WR=3+3k; abort in WR still keeps word k.
            exp_w   = ((ab - 1) % 3 == 2) ? (ab - 1) / 3 + 1 : (ab - 1) / 3;
            exp_cyc = ab + 1;
        end
        for (int i = 0; i < exp_w; i++) ref_mem[d + 32'(4 * i)] = ref_rd(s + 32'(4 * i));

        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = 16'(len);
        start     = 1'b1;
        abort     = 1'b0;
        cyc       = 0;
        ndone     = 0;
        done_cyc  = -1;
        while (cyc < 3 * len + 6) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq("busy_after_start", 32'(busy), 32'd1);
                check_eq("err_cleared", 32'(err), 32'd0);
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                check_eq("busy_low_in_done", 32'(busy), 32'd0);
            end
            start = (cyc == ign);
            if (start) begin
                src_addr  = $urandom;
                dst_addr  = $urandom;
                len_words = 16'($urandom);
            end
            abort = (ab >= 1) && (cyc >= ab) && (ndone == 0);
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        check_eq("done_pulses", 32'(ndone), 32'd1);
        check_eq("words_done", 32'(words_done), 32'(exp_w));
        check_eq("err_copy", 32'(err), 32'd0);
        for (int i = 0; i <= len; i++) begin
            check_eq("dst_word", mem_rd(d + 32'(4 * i)), ref_rd(d + 32'(4 * i)));
        end
    endtask

    // Transfers that must end at once with no bus traffic (len=0 or misaligned).
    task automatic run_short(input logic [31:0] s, input logic [31:0] d, input int len,
                             input logic exp_err);
        int rd0;
        int wr0;
        int done_cyc;
        int ndone;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = 16'(len);
        start     = 1'b1;
        done_cyc  = -1;
        ndone     = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        check_eq("short_done_cycle", 32'(done_cyc), 32'd1);
        check_eq("short_done_pulses", 32'(ndone), 32'd1);
        check_eq("short_err", 32'(err), 32'(exp_err));
        check_eq("short_words", 32'(words_done), 32'd0);
        check_eq("short_rd_traffic", 32'(rd_cnt - rd0), 32'd0);
        check_eq("short_wr_traffic", 32'(wr_cnt - wr0), 32'd0);
    endtask

    initial begin
        int          len;
        int          ab;
        int          ign;
        int          rd0;
        int          wr0;
        int          nd;
        logic [31:0] s;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_words", 32'(words_done), 32'd0);
        check_eq("rst_dm_r", 32'(dm_r), 32'd0);
        check_eq("rst_dm_w", 32'(dm_w), 32'd0);
        check_eq("rst_addr", addr, 32'h0);
        check_eq("rst_wdata", wdata, 32'h0);
        check_eq("rst_dm_op", 32'(dm_op), 32'(`DM_OP_WD));
        rst = 1'b0;
        @(negedge clk);

        // Directed four-word copy with known data.
        for (int i = 0; i < 4; i++) begin
            mem[32'h40 + 32'(4 * i)]     = 32'(i + 1);
            ref_mem[32'h40 + 32'(4 * i)] = 32'(i + 1);
        end
        run_copy(32'h40, 32'h80, 4, 0, 0, 1'b0);
        check_eq("copy4_last", mem_rd(32'h8c), 32'd4);

        run_short(32'h40, 32'h80, 0, 1'b0);
        run_short(32'h42, 32'h80, 2, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("err_sticky", 32'(err), 32'd1);
        run_short(32'h40, 32'h81, 1, 1'b1);

        // A valid copy clears err; then a single word to the LED register.
        mem[32'h200]     = 32'h5a;
        ref_mem[32'h200] = 32'h5a;
        run_copy(32'h200, LedAddr, 1, 0, 0, 1'b0);
        check_eq("io_led", io_led, 32'h5a);

        // Abort held from the third WT (cycle 8) of an eight-word copy.
        run_copy(32'h400, 32'h600, 8, 8, 0, 1'b1);

        // Start and abort together in IDLE: nothing happens.
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        nd  = 0;
        @(negedge clk);
        src_addr  = 32'h40;
        dst_addr  = 32'h80;
        len_words = 16'd2;
        start     = 1'b1;
        abort     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (done || busy) nd++;
        end
        check_eq("abort_beats_start", 32'(nd), 32'd0);
        check_eq("abort_start_traffic", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);

        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(1, 8);
            s   = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            d   = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * len) : 0;
            ign = (ab == 0 && len > 1) ? $urandom_range(2, 3 * len) : 0;
            run_copy(s, d, len, ab, ign, 1'b1);
        end

`ifdef DMA_FILL_EN
        begin
            int fc;
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            fc  = -1;
            @(negedge clk);
            fill_mode  = 1'b1;
            fill_value = 32'hdead_beef;
            src_addr   = 32'h3;
            dst_addr   = 32'h100;
            len_words  = 16'd3;
            start      = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (done && fc < 0) fc = c;
            end
            fill_mode = 1'b0;
            check_eq("fill_done_cycle", 32'(fc), 32'd4);
            check_eq("fill_rd", 32'(rd_cnt - rd0), 32'd0);
            check_eq("fill_wr", 32'(wr_cnt - wr0), 32'd3);
            check_eq("fill_err", 32'(err), 32'd0);
            for (int i = 0; i < 3; i++) begin
                check_eq("fill_word", mem_rd(32'h100 + 32'(4 * i)), 32'hdead_beef);
            end
            for (int i = 0; i < 3; i++) ref_mem[32'h100 + 32'(4 * i)] = 32'hdead_beef;
        end
`endif

        // Reset in the middle of a copy stops all strobes at once.
        @(negedge clk);
        src_addr  = 32'h40;
        dst_addr  = 32'h700;
        len_words = 16'd6;
        start     = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq("midrst_dm_r", 32'(dm_r), 32'd0);
        check_eq("midrst_dm_w", 32'(dm_w), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_words", 32'(words_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        repeat (4) @(negedge clk);
        check_eq("midrst_quiet", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);

        check_eq("no_rd_wr_overlap", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
